// File: rtl/spi_pkg.sv
// Shared types for the SPI master controller: FSM states and SPI mode encoding.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam spi_mode_t MODE0 = 2'b00;
    localparam spi_mode_t MODE1 = 2'b01;
    localparam spi_mode_t MODE2 = 2'b10;
    localparam spi_mode_t MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator: one-cycle tick every (div+1) clk cycles while enabled.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] reload;

    // Down-counter reloaded on accept and on every tick, so each sclk edge is spaced evenly.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt    <= '0;
            reload <= '0;
        end else if (load) begin
            cnt    <= div;
            reload <= div;
        end else if (enable) begin
            if (cnt == '0) begin
                cnt <= reload;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign tick = enable && (cnt == '0);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master controller: start/ready host handshake, all four CPOL/CPHA modes,
// runtime divider, MSB/LSB-first ordering and one-hot active-low slave selects.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 4,
    parameter int DIV_W  = 8,
    localparam int SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              ready,
    output logic              busy,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  div,
    input  logic [SS_W-1:0]   ss_sel,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_SS-1:0] ss_n,
    input  logic              miso
);

    localparam int EDGES = 2 * DATA_W;
    localparam int CNT_W = $clog2(2 * DATA_W + 1);

    state_t            state;
    spi_mode_t         mode;
    logic              lsb_q;
    logic              idle_q;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic [CNT_W-1:0]  edge_cnt;

    logic              tick;
    logic              accept;
    logic [NUM_SS-1:0] ss_dec;
    logic              tx_first;
    logic [DATA_W-1:0] tx_data_nxt;
    logic              tx_cur;
    logic [DATA_W-1:0] tx_sh_nxt;
    logic [DATA_W-1:0] rx_sh_nxt;
    logic              lead;
    logic              do_sample;
    logic              last_edge;

    // ready is forced low while reset is held so nothing can be accepted during reset
    assign ready  = idle_q & reset;
    assign busy   = ~idle_q;
    assign accept = start & ready;

    spi_clk_gen #(
        .DIV_W (DIV_W)
    ) u_clk_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (state != IDLE),
        .load   (accept),
        .div    (div),
        .tick   (tick)
    );

    // Decode the requested slave; out-of-range selects leave every line deasserted.
    always_comb begin
        ss_dec = '1;
        for (int i = 0; i < NUM_SS; i++) begin
            if (ss_sel == SS_W'(i)) begin
                ss_dec[i] = 1'b0;
            end
        end
    end

    // Bit-order aware next values for the tx/rx shift registers and edge classification.
    always_comb begin
        tx_first    = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
        tx_data_nxt = lsb_first ? (tx_data >> 1) : (tx_data << 1);
        tx_cur      = lsb_q ? tx_sh[0] : tx_sh[DATA_W-1];
        tx_sh_nxt   = lsb_q ? (tx_sh >> 1) : (tx_sh << 1);
        rx_sh_nxt   = lsb_q ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
        lead        = ~edge_cnt[0];
        do_sample   = lead ^ mode.cpha;
        last_edge   = (edge_cnt == CNT_W'(EDGES - 1));
    end

    // Transfer FSM with registered pin and handshake outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            idle_q   <= 1'b1;
            mode     <= MODE0;
            lsb_q    <= 1'b0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            edge_cnt <= '0;
            ss_n     <= '1;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    sclk <= cpol;
                    if (accept) begin
                        state    <= SETUP;
                        idle_q   <= 1'b0;
                        mode     <= '{cpol: cpol, cpha: cpha};
                        lsb_q    <= lsb_first;
                        ss_n     <= ss_dec;
                        edge_cnt <= '0;
                        if (!cpha) begin
                            mosi  <= tx_first;
                            tx_sh <= tx_data_nxt;
                        end else begin
                            tx_sh <= tx_data;
                        end
                    end
                end
                SETUP, SHIFT: begin
                    if (tick) begin
                        sclk     <= ~sclk;
                        edge_cnt <= edge_cnt + 1'b1;
                        if (do_sample) begin
                            rx_sh <= rx_sh_nxt;
                        end else if (!last_edge) begin
                            mosi  <= tx_cur;
                            tx_sh <= tx_sh_nxt;
                        end
                        state <= last_edge ? HOLD : SHIFT;
                    end
                end
                HOLD: begin
                    sclk <= mode.cpol;
                    if (tick) begin
                        state    <= IDLE;
                        idle_q   <= 1'b1;
                        ss_n     <= '1;
                        rx_data  <= rx_sh;
                        rx_valid <= 1'b1;
                        sclk     <= cpol;
                    end
                end
                default: begin
                    state  <= IDLE;
                    idle_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed self-checking bench for spi_master_ctrl: 8-bit/4-slave and 16-bit/1-slave instances.
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start, ready, busy, cpol, cpha, lsb_first;
    logic [7:0] div;
    logic [1:0] ss_sel;
    logic [7:0] tx_data, rx_data;
    logic       rx_valid, sclk, mosi, miso;
    logic [3:0] ss_n;

    logic        start2, ready2, busy2, cpol2, cpha2, lsb2;
    logic [7:0]  div2;
    logic [0:0]  ss_sel2;
    logic [15:0] tx2, rx2;
    logic        rx_valid2, sclk2, mosi2, miso2;
    logic [0:0]  ss_n2;

    int checks = 0;
    int errors = 0;

    logic [7:0] sl_word;
    logic       sl_lsb, sl_cpha, loop_en, slave_bit;
    int         sl_cnt = 0;
    int         sl_idx;
    logic       sl_prev = 1'b0;

    int         lat, low_cnt, first_tgl;
    logic [15:0] rx_got;
    logic       mosi_n1, mosi_e2, sclk_n1, sclk_end;
    int         lat1, lat2, gap, low1, vcount;
    logic       seen2;
    logic [7:0] rx1, rx2b;

    spi_master_ctrl #(.DATA_W(8), .NUM_SS(4), .DIV_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .ready(ready), .busy(busy),
        .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .div(div), .ss_sel(ss_sel),
        .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid), .sclk(sclk),
        .mosi(mosi), .ss_n(ss_n), .miso(miso)
    );

    spi_master_ctrl #(.DATA_W(16), .NUM_SS(1), .DIV_W(8)) dut16 (
        .clk(clk), .reset(reset), .start(start2), .ready(ready2), .busy(busy2),
        .cpol(cpol2), .cpha(cpha2), .lsb_first(lsb2), .div(div2), .ss_sel(ss_sel2),
        .tx_data(tx2), .rx_data(rx2), .rx_valid(rx_valid2), .sclk(sclk2),
        .mosi(mosi2), .ss_n(ss_n2), .miso(miso2)
    );

    // Slave model: count sclk edges while selected, present the bit for the current slot.
    always @(sclk or ss_n) begin
        if (&ss_n) begin
            sl_cnt = 0;
        end else if (sclk !== sl_prev) begin
            sl_cnt = sl_cnt + 1;
        end
        sl_prev = sclk;
    end

    always_comb begin
        sl_idx = sl_cpha ? ((sl_cnt > 0) ? (sl_cnt - 1) / 2 : 0) : sl_cnt / 2;
        if (sl_idx > 7) sl_idx = 7;
        slave_bit = sl_lsb ? sl_word[sl_idx] : sl_word[7 - sl_idx];
    end

    assign miso  = loop_en ? mosi : slave_bit;
    assign miso2 = mosi2;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic pol, input logic pha, input logic lsb,
                                 input logic [7:0] dv, input logic [1:0] sel, input logic [7:0] tx);
        @(negedge clk);
        cpol = pol; cpha = pha; lsb_first = lsb; div = dv; ss_sel = sel; tx_data = tx;
        sl_cpha = pha;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
    endtask

    task automatic runXfer(input int h, input logic [3:0] low_pat);
        lat = 0; low_cnt = 0; rx_got = '0;
        for (int n = 1; n <= 4000; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0; mosi_n1 = mosi; sclk_n1 = sclk;
            end
            if (n == 1 + 2 * h) mosi_e2 = mosi;
            if (ss_n == low_pat) low_cnt++;
            if (rx_valid) begin
                lat = n; rx_got = {8'h00, rx_data}; sclk_end = sclk;
                break;
            end
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
        div = 8'd0; ss_sel = 2'd0; tx_data = 8'h00;
        start2 = 1'b0; cpol2 = 1'b0; cpha2 = 1'b0; lsb2 = 1'b0; div2 = 8'd0;
        ss_sel2 = 1'b0; tx2 = 16'h0000;
        sl_word = 8'h00; sl_lsb = 1'b0; sl_cpha = 1'b0; loop_en = 1'b1;
        mosi_n1 = 1'b0; mosi_e2 = 1'b0; sclk_n1 = 1'b0; sclk_end = 1'b0;

        // Reset values while reset is held
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ss_n", ss_n, 4'hF);
        checkOutput("rst_sclk", sclk, 1'b0);
        checkOutput("rst_mosi", mosi, 1'b0);
        checkOutput("rst_rx_data", rx_data, 8'h00);
        checkOutput("rst_rx_valid", rx_valid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_ready_low", ready, 1'b0);
        checkOutput("rst_ss_n16", ss_n2, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("post_rst_ready", ready, 1'b1);
        checkOutput("post_rst_busy", busy, 1'b0);

        // Mode 0, div=1, MSB-first loopback of 0xA5
        loop_en = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd1, 2'd0, 8'hA5);
        runXfer(2, 4'b1110);
        checkOutput("m0_rx", rx_got, 16'h00A5);
        checkOutput("m0_lat", lat, 35);
        checkOutput("m0_ss_low", low_cnt, 34);
        checkOutput("m0_sclk_setup", sclk_n1, 1'b0);

        // Modes 1/2/3 with slave returning 0x3C, div=2
        loop_en = 1'b0; sl_word = 8'h3C; sl_lsb = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd2, 2'd1, 8'h11);
        runXfer(3, 4'b1101);
        checkOutput("m1_rx", rx_got, 16'h003C);
        checkOutput("m1_lat", lat, 52);
        checkOutput("m1_ss_low", low_cnt, 51);
        checkOutput("m1_sclk_end", sclk_end, 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b0, 8'd2, 2'd2, 8'h22);
        runXfer(3, 4'b1011);
        checkOutput("m2_rx", rx_got, 16'h003C);
        checkOutput("m2_sclk_setup", sclk_n1, 1'b1);
        checkOutput("m2_sclk_end", sclk_end, 1'b1);

        applyStimulus(1'b1, 1'b1, 1'b0, 8'd2, 2'd3, 8'h33);
        runXfer(3, 4'b0111);
        checkOutput("m3_rx", rx_got, 16'h003C);
        checkOutput("m3_lat", lat, 52);
        checkOutput("m3_sclk_setup", sclk_n1, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("m3_sclk_idle", sclk, 1'b1);

        // LSB-first: tx=0x01, slave stream 0000_0001 in time order
        sl_word = 8'h80; sl_lsb = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd1, 2'd0, 8'h01);
        runXfer(2, 4'b1110);
        checkOutput("lsb_mosi_first", mosi_n1, 1'b1);
        checkOutput("lsb_mosi_second", mosi_e2, 1'b0);
        checkOutput("lsb_rx", rx_got, 16'h0080);

        // Back-to-back with start held; config changed mid-transfer
        loop_en = 1'b1; sl_lsb = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd1, 2'd2, 8'h5A);
        lat1 = 0; lat2 = 0; gap = 0; low1 = 0; seen2 = 1'b0; rx1 = 8'h00; rx2b = 8'h00;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (n == 1) begin
                ss_sel = 2'd3; tx_data = 8'hC3;
            end
            if (ss_n == 4'b1011) low1++;
            if (rx_valid) begin
                if (lat1 == 0) begin
                    lat1 = n; rx1 = rx_data;
                end else begin
                    lat2 = n; rx2b = rx_data;
                    break;
                end
            end
            if (lat1 != 0 && !seen2 && ss_n == 4'hF) gap++;
            if (!seen2 && ss_n == 4'b0111) begin
                seen2 = 1'b1; start = 1'b0;
            end
        end
        start = 1'b0;
        checkOutput("b2b_lat1", lat1, 35);
        checkOutput("b2b_rx1", rx1, 8'h5A);
        checkOutput("b2b_ss_low1", low1, 34);
        checkOutput("b2b_gap", gap, 1);
        checkOutput("b2b_lat2", lat2, 70);
        checkOutput("b2b_rx2", rx2b, 8'hC3);

        // Reset asserted after sclk edge 5
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd1, 2'd0, 8'hFF);
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (sl_cnt == 5) break;
        end
        checkOutput("rst_mid_edge5_reached", sl_cnt, 5);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mid_ss_n", ss_n, 4'hF);
        checkOutput("rst_mid_sclk", sclk, 1'b0);
        checkOutput("rst_mid_rx_valid", rx_valid, 1'b0);
        checkOutput("rst_mid_busy", busy, 1'b0);
        reset = 1'b1;
        vcount = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (rx_valid) vcount++;
        end
        checkOutput("rst_mid_no_valid", vcount, 0);
        checkOutput("rst_mid_rx_data", rx_data, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd1, 2'd1, 8'h96);
        runXfer(2, 4'b1101);
        checkOutput("after_rst_rx", rx_got, 16'h0096);
        checkOutput("after_rst_lat", lat, 35);

        // 16-bit, single slave, div=255
        @(negedge clk);
        cpol2 = 1'b0; cpha2 = 1'b0; lsb2 = 1'b0; div2 = 8'd255; ss_sel2 = 1'b0; tx2 = 16'hBEEF;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        lat = 0; first_tgl = 0; rx_got = '0;
        for (int n = 1; n <= 10000; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start2 = 1'b0;
                checkOutput("w16_ss_n", ss_n2, 1'b0);
            end
            if (first_tgl == 0 && sclk2) first_tgl = n;
            if (rx_valid2) begin
                lat = n; rx_got = rx2;
                break;
            end
        end
        checkOutput("w16_first_edge", first_tgl, 257);
        checkOutput("w16_lat", lat, 8449);
        checkOutput("w16_rx", rx_got, 16'hBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
